action_ram_arbiter: RTL
=======================

Name: action_ram_arbiter

Overview:
- Sequences and shares the board/action RAM between two requesters: player-move logic (p0) and the move-evaluation engine (p1).
- Also runs a board-clear sequence that zero-fills a contiguous address window at game start.
- Sits between the requesters and the RAM's write port (write_enable, write_address, d_in) and read port (read_address, d_out, 1-clock synchronous read).
- Exactly one RAM transaction is in flight at any time.

Parameters:
ADDR_W, 18, RAM address width (write and read addresses).
DATA_W, 16, RAM data width.
CLEAR_BASE, 0, first address zeroed by the clear sequence.
CLEAR_LEN, 9, number of consecutive addresses zeroed (one per board cell); must be at least 1.

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous, active-low reset
clear_start  in  1  one-cycle pulse requesting a board clear
clear_busy  out  1  high while a clear is pending or in progress
p0_req  in  1  p0 request; hold high with p0_we/p0_addr/p0_wdata stable until p0_gnt
p0_we  in  1  1 = write, 0 = read
p0_addr  in  ADDR_W  p0 address
p0_wdata  in  DATA_W  p0 write data
p0_gnt  out  1  one-cycle pulse: request accepted
p0_rvalid  out  1  one-cycle pulse: p0_rdata is valid
p0_rdata  out  DATA_W  read data, held until the next p0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as the p0 ports, for p1
ram_write_enable  out  1  to RAM write_enable
ram_write_address  out  ADDR_W  to RAM write_address
ram_d_in  out  DATA_W  to RAM d_in
ram_read_address  out  ADDR_W  to RAM read_address
ram_d_out  in  DATA_W  from RAM d_out

Behaviour:
- States: IDLE, ISSUE, WAIT, CLEAR. All outputs are registered.
- Reset (asynchronous, immediate): state IDLE; every output 0; last_winner = p1 (so p0 wins the first tie); clear counter 0; clear_pending 0.
- Reset mid-transaction: the transaction is abandoned, ram_write_enable drops at once, and no gnt or rvalid is produced afterwards.
- IDLE, priority order at each edge:
  1. clear_pending or clear_start set: go to CLEAR.
  2. Otherwise, exactly one req high: grant that requester.
  3. Otherwise, both req high: grant the requester that is not last_winner (round-robin).
- On grant (edge E1): go to ISSUE; pulse the winner's gnt for one cycle; update last_winner.
  - Write: ram_write_enable=1, ram_write_address=addr, ram_d_in=wdata.
  - Read: ram_read_address=addr, ram_write_enable=0.
- ISSUE (edge E2): the RAM samples the request. ram_write_enable returns to 0.
  - Write: go to IDLE. A write occupies 2 cycles.
  - Read: go to WAIT.
- WAIT (edge E3): capture ram_d_out into the winner's rdata; pulse the winner's rvalid for the cycle after E3; go to IDLE.
  - Read latency: rvalid arrives 2 cycles after gnt. A read occupies 3 cycles.
- A requester may re-raise req in the cycle after gnt. It is considered again at the next IDLE edge.
- ram_read_address and ram_write_address hold their last values when not in use. Addresses pass through unmodified, with no range check.
- clear_start while not in IDLE: set clear_pending. The clear starts at the next IDLE edge, ahead of any waiting req. The in-flight transaction completes normally.
- clear_start while already in CLEAR: ignored.
- clear_busy = clear_pending OR (state == CLEAR).
- CLEAR: for k = 0 .. CLEAR_LEN-1, one write per cycle: ram_write_enable=1, ram_write_address=CLEAR_BASE+k, ram_d_in=0. After the last write: ram_write_enable=0, clear counter reset, clear_pending cleared, return to IDLE.
  - The clear takes CLEAR_LEN+1 cycles from entry to IDLE.
  - No gnt is issued while clear_busy is high.
- Arithmetic: CLEAR_BASE+k is ADDR_W bits and wraps modulo 2^ADDR_W.

Test Plan:
- Write then read, single requester: p0 writes 0x0002 to addr 4, then reads addr 4 -> gnt one cycle after each req; RAM write_enable high exactly one cycle with address 4 and data 0x0002; p0_rvalid 2 cycles after the read gnt with p0_rdata=0x0002.
- Contention: p0 and p1 both hold read requests continuously from reset -> grants alternate p0, p1, p0, p1; each rvalid appears on the matching requester only; no cycle where both gnt are high.
- Clear with defaults: preload addrs 0..8 with 0x0001; pulse clear_start -> writes of 0 to addresses 0..8 on 9 consecutive cycles; clear_busy high throughout; subsequent reads of addrs 0..8 return 0x0000; addr 9 unchanged.
- Clear during a read: p1 read in ISSUE when clear_start pulses -> p1_rvalid still delivered with correct data; clear_busy rises immediately; clear begins at the next IDLE edge ahead of a pending p0_req; p0 is granted after the clear completes.
- Reset mid-write: drop reset_n while ram_write_enable=1 -> ram_write_enable, all gnt and all rvalid go 0 immediately; after release, the first tie is granted to p0.
- Wrap: CLEAR_BASE=2^18-2, CLEAR_LEN=4 -> clear write addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.

Source files
------------

// File: rtl/action_ram_arbiter.sv
`timescale 1ns/1ps
// action_ram_arbiter
//
// Shares one board/action RAM between two requesters: the player-move logic
// (p0) and the move-evaluation engine (p1). It also runs a board-clear
// sequence that zero-fills a contiguous address window at game start.
// Exactly one RAM transaction is in flight at a time. Ties between p0 and p1
// are broken round-robin, and a pending clear always goes ahead of any waiting
// request.
//
// Ports
//   clock, reset_n            system clock, asynchronous active-low reset
//   clear_start / clear_busy  clear request pulse / clear pending-or-running
//   pN_req/we/addr/wdata      requester N command, held stable until pN_gnt
//   pN_gnt                    one-cycle pulse: command accepted
//   pN_rvalid / pN_rdata      one-cycle pulse / read data (held until next read)
//   ram_write_enable, ram_write_address, ram_d_in   RAM write port
//   ram_read_address, ram_d_out                     RAM read port (1-clock read)
module action_ram_arbiter #(
  parameter int          ADDR_W     = 18,
  parameter int          DATA_W     = 16,
  parameter int unsigned CLEAR_BASE = 0,
  parameter int unsigned CLEAR_LEN  = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [ADDR_W-1:0] ram_read_address,
  input  logic [DATA_W-1:0] ram_d_out
);

  // The clear counter must be able to hold CLEAR_LEN itself, which marks the
  // "all writes issued" step.
  localparam int                CNT_W  = (CLEAR_LEN < 2) ? 1 : $clog2(CLEAR_LEN + 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(CLEAR_BASE);
  localparam logic [CNT_W-1:0]  LAST_K = CNT_W'(CLEAR_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR} state_t;

  state_t            state;
  logic              last_winner;    // 1 = p1 won the most recent grant
  logic              owner;          // 1 = in-flight transaction belongs to p1
  logic              op_read;        // in-flight transaction is a read
  logic              clear_pending;
  logic [CNT_W-1:0]  clr_cnt;

  logic              pick_p1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // p1 wins when it is the only requester, or on a tie when p0 won last time.
  assign pick_p1   = p1_req && (!p0_req || !last_winner);
  assign sel_we    = pick_p1 ? p1_we    : p0_we;
  assign sel_addr  = pick_p1 ? p1_addr  : p0_addr;
  assign sel_wdata = pick_p1 ? p1_wdata : p0_wdata;

  // NOTE: all state and outputs are registers updated with non-blocking
  // assignments, so every branch below reads the values from before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      last_winner       <= 1'b1;
      owner             <= 1'b0;
      op_read           <= 1'b0;
      clear_pending     <= 1'b0;
      clr_cnt           <= '0;
      clear_busy        <= 1'b0;
      p0_gnt            <= 1'b0;
      p0_rvalid         <= 1'b0;
      p0_rdata          <= '0;
      p1_gnt            <= 1'b0;
      p1_rvalid         <= 1'b0;
      p1_rdata          <= '0;
      ram_write_enable  <= 1'b0;
      ram_write_address <= '0;
      ram_d_in          <= '0;
      ram_read_address  <= '0;
    end else begin
      // NOTE: pulse outputs default low here so each branch only raises the
      // one it needs; nothing can be left stuck high by a forgotten branch.
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (clear_pending || clear_start) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
          end else if (p0_req || p1_req) begin
            state       <= S_ISSUE;
            owner       <= pick_p1;
            last_winner <= pick_p1;
            op_read     <= !sel_we;
            p0_gnt      <= !pick_p1;
            p1_gnt      <= pick_p1;
            clear_busy  <= 1'b0;
            if (sel_we) begin
              ram_write_enable  <= 1'b1;
              ram_write_address <= sel_addr;
              ram_d_in          <= sel_wdata;
            end else begin
              ram_write_enable  <= 1'b0;
              ram_read_address  <= sel_addr;
            end
          end else begin
            clear_busy <= 1'b0;
          end
        end

        S_ISSUE: begin
          // The RAM samples the command on this edge.
          ram_write_enable <= 1'b0;
          state            <= op_read ? S_WAIT : S_IDLE;
          if (clear_start) begin
            clear_pending <= 1'b1;
            clear_busy    <= 1'b1;
          end
        end

        S_WAIT: begin
          if (owner) begin
            p1_rdata  <= ram_d_out;
            p1_rvalid <= 1'b1;
          end else begin
            p0_rdata  <= ram_d_out;
            p0_rvalid <= 1'b1;
          end
          state <= S_IDLE;
          if (clear_start) begin
            clear_pending <= 1'b1;
            clear_busy    <= 1'b1;
          end
        end

        S_CLEAR: begin
          // First cycle in CLEAR is a setup cycle; writes k = 0..LEN-1 follow,
          // then one closing edge that drops write_enable and returns to IDLE.
          // clear_start is ignored while a clear is already running.
          if (clr_cnt == LAST_K) begin
            state            <= S_IDLE;
            ram_write_enable <= 1'b0;
            clr_cnt          <= '0;
            clear_pending    <= 1'b0;
            clear_busy       <= 1'b0;
          end else begin
            ram_write_enable  <= 1'b1;
            ram_write_address <= BASE_A + ADDR_W'(clr_cnt);  // wraps mod 2^ADDR_W
            ram_d_in          <= '0;
            clr_cnt           <= clr_cnt + 1'b1;
            clear_busy        <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
